// File: rtl/instr_sequencer.sv
// Program sequencer: loadable program store, in-order fetch, valid/ready issue to the core.
// Interprets JMP (4'hE) and HALT (4'hF) locally and forwards every other word unchanged.
module instr_sequencer #(
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [0:11]   load_data_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          instr_ready_i,
    output logic [0:11]   instr_out_o,
    output logic          instr_valid_o,
    output logic [AW-1:0] pc_o,
    output logic          busy_o,
    output logic          halted_o,
    output logic          err_o
);

    localparam int unsigned DW    = 12;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [AW-1:0] PC_LAST = {AW{1'b1}};
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [0:DW-1] ir_q, ir_d;
    logic [0:DW-1] out_q, out_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          halted_q, halted_d;

    logic [0:DW-1] mem [DEPTH];
    logic [0:DW-1] rd_word;
    logic          can_load;
    logic          rd_is_ctrl;

    assign can_load   = (state_q == S_IDLE) || (state_q == S_HALT);
    assign rd_word    = mem[pc_q];
    assign rd_is_ctrl = (rd_word[0:3] == OP_JMP) || (rd_word[0:3] == OP_HALT);

    // Program store is not reset; writes only while not executing
    always_ff @(posedge clk) begin
        if (load_en_i && can_load) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    // Control words are decoded at fetch time so they never raise instr_valid
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        out_d   = out_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (abort_i) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            out_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start_i) begin
                        pc_d    = '0;
                        err_d   = 1'b0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir_d    = rd_word;
                    state_d = S_ISSUE;
                    if (!rd_is_ctrl) begin
                        valid_d = 1'b1;
                        out_d   = rd_word;
                    end
                end
                default: begin
                    if (ir_q[0:3] == OP_HALT) begin
                        state_d = S_HALT;
                    end else if (ir_q[0:3] == OP_JMP) begin
                        pc_d    = AW'(ir_q[4:11]);
                        state_d = S_FETCH;
                    end else if (instr_ready_i) begin
                        valid_d = 1'b0;
                        out_d   = '0;
                        if (pc_q == PC_LAST) begin
                            err_d   = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            pc_d    = pc_q + AW'(1);
                            state_d = S_FETCH;
                        end
                    end
                end
            endcase
        end
        busy_d   = (state_d == S_FETCH) || (state_d == S_ISSUE);
        halted_d = (state_d == S_HALT);
    end

    assign instr_out_o   = out_q;
    assign instr_valid_o = valid_q;
    assign pc_o          = pc_q;
    assign busy_o        = busy_q;
    assign halted_o      = halted_q;
    assign err_o         = err_q;

endmodule
